// File: rtl/load_store_unit.sv
// Load/store unit between the CPU and a word-wide memory: sub-word loads with extension and
// sub-word stores via read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        RDATA,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;

    logic                  store_q, store_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  ready_d, valid_d, err_d, we_d;
    logic [DATA_WIDTH-1:0] rdata_d, mwdata_d;
    logic [ADDR_WIDTH-1:0] maddr_d;
    logic                  misalign_c;

    // Select the addressed lane of a memory word and zero/sign-extend it.
    function automatic logic [DATA_WIDTH-1:0] extend_lane(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [1:0] size,
                                                          input logic [1:0] lane,
                                                          input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace only the addressed byte/half lanes of the read word.
    function automatic logic [DATA_WIDTH-1:0] merge_lane(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [DATA_WIDTH-1:0] wdata,
                                                         input logic [1:0] size,
                                                         input logic [1:0] lane);
        logic [DATA_WIDTH-1:0] out;
        out = word;
        case (size)
            2'b00:   out[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   out[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: out = wdata;
        endcase
        return out;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
        end else begin
            state      <= state_next;
            req_ready  <= ready_d;
            resp_valid <= valid_d;
            resp_data  <= rdata_d;
            resp_err   <= err_d;
            mem_addr   <= maddr_d;
            mem_wdata  <= mwdata_d;
            mem_we     <= we_d;
            store_q    <= store_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_next = state;
        valid_d    = 1'b0;
        we_d       = 1'b0;
        rdata_d    = resp_data;
        err_d      = resp_err;
        maddr_d    = mem_addr;
        mwdata_d   = mem_wdata;
        store_d    = store_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (misalign_c) begin
                        state_next = DONE;
                        valid_d    = 1'b1;
                        rdata_d    = '0;
                        err_d      = 1'b1;
                    end else begin
                        maddr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_store && req_size[1]) begin
                            state_next = WRITE;
                            we_d       = 1'b1;
                            mwdata_d   = req_wdata;
                        end else begin
                            state_next = ISSUE;
                        end
                    end
                end
            end
            ISSUE: state_next = RDATA;
            RDATA: begin
                if (store_q) begin
                    state_next = WRITE;
                    we_d       = 1'b1;
                    mwdata_d   = merge_lane(mem_rdata, wdata_q, size_q, lane_q);
                end else begin
                    state_next = DONE;
                    valid_d    = 1'b1;
                    rdata_d    = extend_lane(mem_rdata, size_q, lane_q, uns_q);
                    err_d      = 1'b0;
                end
            end
            WRITE: begin
                state_next = DONE;
                valid_d    = 1'b1;
                rdata_d    = '0;
                err_d      = 1'b0;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        ready_d = (state_next == IDLE);
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-edge-latency word memory model.
// Build with LSU_MISALIGN_TRAP_EN defined to exercise the misalignment trap.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int fails  = 0;
    int we_cnt = 0;
    int resp_cnt = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    // Memory latches the request at each edge; a latched write lands one edge later.
    logic [31:0] mem [64];
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_we;

    always @(posedge clk) begin
        if (lat_we) mem[lat_addr[7:2]] <= lat_wdata;
        lat_addr  <= mem_addr;
        lat_wdata <= mem_wdata;
        lat_we    <= mem_we;
    end
    assign mem_rdata = mem[lat_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] data, output logic err);
        @(negedge clk);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 99;
        data = 32'hxxxx_xxxx;
        err  = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat  = k;
                data = resp_data;
                err  = resp_err;
                break;
            end
        end
    endtask

    int          lat, we0, r0, a0;
    logic [31:0] data;
    logic        err;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;

        // word store then load
        we0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, data, err);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_data", data, 32'h0);
        check("sw_we_pulses", 32'(we_cnt - we0), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, data, err);
        check("lw_lat", 32'(lat), 32'd3);
        check("lw_data", data, 32'hDEADBEEF);
        check("lw_err", 32'(err), 32'd0);

        // byte RMW
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h11223344, lat, data, err);
        we0 = we_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, lat, data, err);
        check("sb_lat", 32'(lat), 32'd4);
        check("sb_we_pulses", 32'(we_cnt - we0), 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, data, err);
        check("sb_readback", data, 32'h11AA3344);

        // sub-word loads with extension
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h8000FF80, lat, data, err);
        do_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, lat, data, err);
        check("lb_30", data, 32'hFFFFFF80);
        check("lb_lat", 32'(lat), 32'd3);
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, lat, data, err);
        check("lhu_32", data, 32'h00008000);
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, lat, data, err);
        check("lh_32", data, 32'hFFFF8000);
        do_req(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, lat, data, err);
        check("lbu_31", data, 32'h000000FF);
        do_req(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, lat, data, err);
        check("lb_31", data, 32'hFFFFFFFF);
        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF1234, lat, data, err);
        check("sh_lat", 32'(lat), 32'd4);
        do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, data, err);
        check("sh_readback", data, 32'h1234FF80);

        // reset during RDATA of a half store
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, lat, data, err);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        we0 = we_cnt;
        r0  = resp_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rmw_rst_ready", 32'(req_ready), 32'd1);
        repeat (6) @(negedge clk);
        check("rmw_rst_no_we", 32'(we_cnt - we0), 32'd0);
        check("rmw_rst_no_resp", 32'(resp_cnt - r0), 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, data, err);
        check("rmw_rst_word", data, 32'hCAFEF00D);

        // req_valid held high across back-to-back loads
        @(negedge clk);
        a0 = acc_cnt;
        r0 = resp_cnt;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("hold_busy_ready", 32'(req_ready), 32'd0);
        repeat (11) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_accepts", 32'(acc_cnt - a0), 32'd3);
        check("hold_resps", 32'(resp_cnt - r0), 32'd3);
        check("hold_data", resp_data, 32'hDEADBEEF);

        // misaligned word load
        we0 = we_cnt;
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, data, err);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(err), 32'd1);
        check("mis_data", data, 32'h0);
        check("mis_mem_addr", mem_addr, 32'h10);
`else
        check("mis_lat", 32'(lat), 32'd3);
        check("mis_err", 32'(err), 32'd0);
        check("mis_data", data, 32'hDEADBEEF);
`endif
        check("mis_no_we", 32'(we_cnt - we0), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width of req_addr and mem_addr.
REQ-002 Port: clk  input  1  clock; all state changes on posedge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  input  1  CPU access request.
REQ-005 Port: req_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: req_store  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 Port: req_unsigned  input  1  load zero-extend (1) or sign-extend (0).
REQ-009 Port: req_addr  input  ADDR_WIDTH  byte address.
REQ-010 Port: req_wdata  input  32  store data; sub-word data in low bits.
REQ-011 Port: resp_valid  output  1  one-cycle completion pulse, loads and stores.
REQ-012 Port: resp_data  output  32  extended load result; 0 for stores.
REQ-013 Port: resp_err  output  1  misaligned-access flag.
REQ-014 Port: mem_addr  output  ADDR_WIDTH  word-memory address, registered.
REQ-015 Port: mem_wdata  output  32  word-memory write data, registered.
REQ-016 Port: mem_we  output  1  word-memory write enable, registered.
REQ-017 Port: mem_rdata  input  32  word-memory read data, valid in the second cycle after mem_addr is driven.

Function
REQ-018 Downstream memory latches mem_addr/mem_wdata/mem_we at each posedge; the write commits one edge later; mem_rdata reflects the latched address.
REQ-019 States: IDLE, ISSUE, RDATA, WRITE, DONE; req_ready=1 only in IDLE.
REQ-020 Acceptance: req_valid && req_ready at a posedge captures all req_* fields; otherwise req_* are ignored.
REQ-021 Word store: IDLE->WRITE, with mem_we=1 and mem_wdata=req_wdata for exactly one cycle, then DONE; resp_valid 2 cycles after the acceptance edge.
REQ-022 Load: IDLE->ISSUE->RDATA->DONE; mem_we=0; in RDATA the selected lane of mem_rdata is extended into resp_data; resp_valid 3 cycles after the acceptance edge.
REQ-023 Sub-word store: IDLE->ISSUE->RDATA->WRITE->DONE (read-modify-write); only the addressed byte/half lanes of the read word are replaced; mem_we=1 only in WRITE; resp_valid 4 cycles after the acceptance edge.
REQ-024 Lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1]; word ignores addr[1:0]; mem_addr = req_addr with bits [1:0] cleared.
REQ-025 DONE lasts one cycle with resp_valid=1 and returns to IDLE; resp_data/resp_err hold until the next DONE.
REQ-026 mem_we is never asserted outside WRITE; at most one write per request.
REQ-027 A load issued after a completed store to the same word returns the stored value.

Reset
REQ-028 rst in any state: next state IDLE; req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_we=0.
REQ-029 Reset mid-RMW discards the pending write; no resp_valid is produced for the aborted request.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->DONE with no memory access; resp_err=1, resp_data=0, resp_valid 1 cycle after the acceptance edge.
REQ-031 Macro undefined: resp_err is tied to 0, and misaligned addresses are silently aligned per REQ-024.

Verification
REQ-032 Word store 0xDEADBEEF to 0x10, then word load 0x10 -> resp_data=0xDEADBEEF; store resp_valid at +2 cycles, load at +3.
REQ-033 Word at 0x20 = 0x11223344; byte store 0xAA to 0x22 -> word 0x11AA3344, exactly one mem_we pulse; resp_valid at +4.
REQ-034 Word 0x8000FF80 at 0x30: signed byte load 0x30 -> 0xFFFFFF80; unsigned half load 0x32 -> 0x00008000; signed half load 0x32 -> 0xFFFF8000.
REQ-035 rst asserted in RDATA of a half store to 0x40 -> no mem_we, no resp_valid; word at 0x40 unchanged; req_ready=1 the cycle after reset.
REQ-036 req_valid held high throughout a load -> second request accepted only in IDLE after DONE; exactly one resp_valid per accepted request.
REQ-037 Word load from 0x13: with LSU_MISALIGN_TRAP_EN -> resp_err=1, resp_data=0, no memory access; without it -> data of word 0x10, resp_err=0.
